operm_kp_gen: RTL and testbench
===============================

OPERM_KP_GEN -- requirements
Module: operm_kp_gen

Interface
Parameters (name, default, meaning):
REQ-001 SLICES, 8, number of permutator slices; SHALL be a power of two and at least 2.
REQ-002 LOG2SLICES, 3, log2(SLICES); also the per-slice address width PERIN.
REQ-003 SELIN, 2, width of the selector/control field carried ahead of the addresses.
REQ-004 LENW, 8, width of the beat-count field.

Ports (name, direction, width, meaning):
REQ-005 clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 reset, input, 1, synchronous, active-high reset.
REQ-007 t_cmd_dat, input, 2+1+LOG2SLICES+SELIN+LENW, command; fields from MSB: mode[1:0], step, amt, sel, len.
REQ-008 t_cmd_valid, input, 1, command valid.
REQ-009 t_cmd_ready, output, 1, command accept.
REQ-010 i_kp_dat, output, SELIN+SLICES*LOG2SLICES, key word; the SELIN MSBs SHALL hold sel; slice i address SHALL occupy [LOG2SLICES*(i+1)-1 : LOG2SLICES*i].
REQ-011 i_kp_valid, output, 1, key word valid.
REQ-012 i_kp_ready, input, 1, downstream accept.
REQ-013 i_kp_last, output, 1, marks the final beat of a command.

Function
REQ-014 Transfer rule: a transfer SHALL occur on a cycle where valid and ready are both high, on either interface.
REQ-015 State machine SHALL have two states, IDLE and RUN.
REQ-016 In IDLE, t_cmd_ready SHALL be 1 and i_kp_valid SHALL be 0.
REQ-017 In RUN, t_cmd_ready SHALL be 0 and i_kp_valid SHALL be 1.
REQ-018 A command transfer in IDLE SHALL latch mode, step, amt, sel and len, load the beat counter with len, and enter RUN on the next cycle.
REQ-019 The first key word SHALL be valid on the cycle after command acceptance, giving a latency of 1.
REQ-020 A command SHALL produce exactly len+1 beats, so len=0 yields one beat.
REQ-021 Slice address addr_i SHALL be a LOG2SLICES-bit value per mode:
  - mode 0: i (identity)
  - mode 1: (i + amt) mod SLICES (rotate)
  - mode 2: i XOR amt (butterfly swap)
  - mode 3: SLICES-1-i (reverse)
REQ-022 All mode arithmetic SHALL wrap modulo SLICES with no carry out.
REQ-023 i_kp_dat, i_kp_last and i_kp_valid SHALL be registered outputs.
REQ-024 While i_kp_valid=1 and i_kp_ready=0, all three SHALL hold stable.
REQ-025 On each key transfer with step=1, amt SHALL increment modulo SLICES for the next beat; with step=0, amt SHALL stay constant.
REQ-026 i_kp_last SHALL be 1 only on the beat where the counter equals 0.
REQ-027 A transfer of the last beat SHALL return the machine to IDLE on the next cycle.
REQ-028 A new command SHALL NOT be accepted in the same cycle as the last-beat transfer, giving one idle cycle between commands.
REQ-029 t_cmd_valid in RUN SHALL be ignored and SHALL NOT corrupt the latched fields.
REQ-030 sel SHALL be constant across all beats of a command.

Reset
REQ-031 While reset=1, the block SHALL enter IDLE with i_kp_valid=0, i_kp_last=0, i_kp_dat=0 and t_cmd_ready=0.
REQ-032 t_cmd_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-033 Reset asserted mid-RUN SHALL abandon the command immediately, emitting no further beats.
REQ-034 Reset SHALL take priority over every simultaneous handshake.

Verification
REQ-035 Identity test: mode0, sel=2, len=0, ready=1 -> one beat, addrs 0..7, sel=2, last=1, valid exactly one cycle.
REQ-036 Stepped rotate test: mode1, amt=3, step=1, len=2, ready=1 -> three beats:
  - slice0 addr 3, 4, 5
  - slice7 addr 2, 3, 4
  - last on beat 3 only
REQ-037 Wrap test: mode2, amt=7, step=1, len=1 -> beat0 slice0=7; beat1 amt wraps to 0, slice0=0, slice5=5.
REQ-038 Backpressure test: mode3, len=3, ready toggled 1,0,0,1,... -> i_kp_dat and i_kp_last stable during stalls; exactly 4 transfers; slice0=7 throughout.
REQ-039 Mid-run reset test: reset pulsed after 2 of 5 beats -> valid=0 the next cycle; a new len=0 command afterwards yields exactly 1 beat.
REQ-040 Ignored-command test: t_cmd_valid held high through RUN -> ready=0 in RUN; the second command is accepted only after the idle gap (REQ-028).

Source files
------------

// File: rtl/operm_kp_gen.sv
// Permutation key generator: each accepted command emits len+1 key words holding
// a per-slice address map (identity/rotate/butterfly/reverse) plus a selector field.
module operm_kp_gen #(
  parameter int SLICES     = 8,
  parameter int LOG2SLICES = 3,
  parameter int SELIN      = 2,
  parameter int LENW       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2+1+LOG2SLICES+SELIN+LENW-1:0] t_cmd_dat,
  input  logic                                t_cmd_valid,
  output logic                                t_cmd_ready,
  output logic [SELIN+SLICES*LOG2SLICES-1:0]  i_kp_dat,
  output logic                                i_kp_valid,
  input  logic                                i_kp_ready,
  output logic                                i_kp_last,
  output logic                                state_dbg
);

  localparam int L  = LOG2SLICES;
  localparam int KW = SELIN + SLICES * L;

  // Both interfaces: a beat moves on a rising edge where valid && ready.
  // Neither valid depends combinationally on its own ready.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [1:0]       cmd_mode;
  logic             cmd_step;
  logic [L-1:0]     cmd_amt;
  logic [SELIN-1:0] cmd_sel;
  logic [LENW-1:0]  cmd_len;

  assign {cmd_mode, cmd_step, cmd_amt, cmd_sel, cmd_len} = t_cmd_dat;

  logic [1:0]       mode_q;
  logic             step_q;
  logic [L-1:0]     amt_q;
  logic [SELIN-1:0] sel_q;
  logic [LENW-1:0]  cnt_q;
  logic [L-1:0]     amt_nxt;
  logic             cmd_fire;
  logic             kp_fire;

  assign cmd_fire = t_cmd_valid && t_cmd_ready;
  assign kp_fire  = i_kp_valid && i_kp_ready;
  assign amt_nxt  = step_q ? amt_q + L'(1) : amt_q;
  assign state_dbg = (state == RUN);

  // All address arithmetic is L bits wide, so it wraps modulo SLICES for free.
  function automatic logic [KW-1:0] make_key(input logic [1:0] m,
                                              input logic [L-1:0] a,
                                              input logic [SELIN-1:0] s);
    logic [KW-1:0] k;
    logic [L-1:0]  idx;
    k = '0;
    k[KW-1 -: SELIN] = s;
    for (int i = 0; i < SLICES; i++) begin
      idx = i[L-1:0];
      case (m)
        2'd0:    k[L*i +: L] = idx;
        2'd1:    k[L*i +: L] = idx + a;
        2'd2:    k[L*i +: L] = idx ^ a;
        default: k[L*i +: L] = ~idx;
      endcase
    end
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = RUN;
      RUN:     if (kp_fire && i_kp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    t_cmd_ready = 1'b0;
    i_kp_valid  = 1'b0;
    case (state)
      IDLE:    t_cmd_ready = !reset;
      RUN:     i_kp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Key word and last flag are computed one beat ahead so they leave from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= '0;
      step_q    <= 1'b0;
      amt_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      i_kp_dat  <= '0;
      i_kp_last <= 1'b0;
    end else if (cmd_fire) begin
      mode_q    <= cmd_mode;
      step_q    <= cmd_step;
      amt_q     <= cmd_amt;
      sel_q     <= cmd_sel;
      cnt_q     <= cmd_len;
      i_kp_dat  <= make_key(cmd_mode, cmd_amt, cmd_sel);
      i_kp_last <= (cmd_len == '0);
    end else if (kp_fire) begin
      if (i_kp_last) begin
        i_kp_last <= 1'b0;
      end else begin
        amt_q     <= amt_nxt;
        cnt_q     <= cnt_q - LENW'(1);
        i_kp_dat  <= make_key(mode_q, amt_nxt, sel_q);
        i_kp_last <= (cnt_q == LENW'(1));
      end
    end
  end

endmodule

// File: tb/tb_operm_kp_gen.sv
// Bench for operm_kp_gen: directed scenarios plus random commands, each beat
// checked against a slice-address model computed straight from the mode rules.
module tb_operm_kp_gen;
  localparam int SLICES = 8;
  localparam int L      = 3;
  localparam int SELIN  = 2;
  localparam int LENW   = 8;
  localparam int KW     = SELIN + SLICES * L;
  localparam int CW     = 2 + 1 + L + SELIN + LENW;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] t_cmd_dat;
  logic          t_cmd_valid;
  logic          t_cmd_ready;
  logic [KW-1:0] i_kp_dat;
  logic          i_kp_valid;
  logic          i_kp_ready;
  logic          i_kp_last;
  logic          state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [KW:0] exp_q[$];

  operm_kp_gen #(.SLICES(SLICES), .LOG2SLICES(L), .SELIN(SELIN), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .t_cmd_dat(t_cmd_dat), .t_cmd_valid(t_cmd_valid), .t_cmd_ready(t_cmd_ready),
    .i_kp_dat(i_kp_dat), .i_kp_valid(i_kp_valid), .i_kp_ready(i_kp_ready),
    .i_kp_last(i_kp_last), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [KW-1:0] ref_key(input int mode, input int amt, input int sel);
    logic [KW-1:0] k;
    int a;
    k = '0;
    for (int i = 0; i < SLICES; i++) begin
      case (mode)
        0:       a = i;
        1:       a = (i + amt) % SLICES;
        2:       a = i ^ amt;
        default: a = SLICES - 1 - i;
      endcase
      k[i*L +: L] = a[L-1:0];
    end
    k[KW-1 -: SELIN] = sel[SELIN-1:0];
    return k;
  endfunction

  function automatic logic [CW-1:0] pack_cmd(input int mode, input int step, input int amt,
                                             input int sel, input int len);
    return {mode[1:0], step[0], amt[L-1:0], sel[SELIN-1:0], len[LENW-1:0]};
  endfunction

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_cmd(input int mode, input int step, input int amt, input int sel,
                         input int len, input int rmode, input bit hold,
                         input logic [CW-1:0] nxt, output int beats);
    int cyc;
    logic stalled;
    logic [KW-1:0] hd;
    logic hl;
    logic [KW:0] e;
    exp_q.delete();
    for (int b = 0; b <= len; b++)
      exp_q.push_back({(b == len), ref_key(mode, (amt + (step != 0 ? b : 0)) % SLICES, sel)});
    n_cmp++;
    if (t_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_idle: got %b want 1", t_cmd_ready);
    end
    t_cmd_dat   = pack_cmd(mode, step, amt, sel, len);
    t_cmd_valid = 1'b1;
    i_kp_ready  = 1'b0;
    @(negedge clk);
    if (hold) t_cmd_dat = nxt;
    else      t_cmd_valid = 1'b0;
    n_cmp++;
    if (i_kp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_beat_latency: valid %b want 1", i_kp_valid);
    end
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      n_cmp++;
      if (i_kp_valid !== 1'b1 || t_cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL run_handshake: valid %b cmd_ready %b want 1/0", i_kp_valid, t_cmd_ready);
      end
      if (stalled) begin
        n_cmp++;
        if ({i_kp_last, i_kp_dat} !== {hl, hd}) begin
          n_err++;
          $display("FAIL stall_hold: got %h want %h", {i_kp_last, i_kp_dat}, {hl, hd});
        end
      end
      case (rmode)
        0:       i_kp_ready = 1'b1;
        1:       i_kp_ready = 1'($urandom_range(0, 1));
        default: i_kp_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      if (i_kp_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({i_kp_last, i_kp_dat} !== e) begin
          n_err++;
          $display("FAIL beat_data: beat %0d got last/dat %h want %h", beats, {i_kp_last, i_kp_dat}, e);
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd = i_kp_dat;
        hl = i_kp_last;
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d beats outstanding want 0", exp_q.size());
    end
    i_kp_ready = 1'b0;
    n_cmp++;
    if (i_kp_valid !== 1'b0 || t_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_gap: valid %b cmd_ready %b want 0/1", i_kp_valid, t_cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    t_cmd_valid = 1'b1;
    t_cmd_dat = pack_cmd(1, 1, 5, 3, 2);
    i_kp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (i_kp_valid !== 1'b0 || i_kp_last !== 1'b0 || i_kp_dat !== '0 || t_cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: valid %b last %b dat %h cmd_ready %b want 0/0/0/0",
                 i_kp_valid, i_kp_last, i_kp_dat, t_cmd_ready);
      end
    end
    reset = 1'b0;
    t_cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (t_cmd_ready !== 1'b1 || i_kp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: cmd_ready %b valid %b want 1/0", t_cmd_ready, i_kp_valid);
    end
  endtask

  task automatic expect_beats(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: beats %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_identity();
    int b;
    run_cmd(0, 0, 0, 2, 0, 0, 1'b0, '0, b);
    expect_beats("identity_beats", b, 1);
  endtask

  task automatic test_rotate_step();
    int b;
    run_cmd(1, 1, 3, 1, 2, 0, 1'b0, '0, b);
    expect_beats("rotate_beats", b, 3);
  endtask

  task automatic test_wrap();
    int b;
    run_cmd(2, 1, 7, 3, 1, 0, 1'b0, '0, b);
    expect_beats("wrap_beats", b, 2);
  endtask

  task automatic test_backpressure();
    int b;
    run_cmd(3, 0, 0, 1, 3, 2, 1'b0, '0, b);
    expect_beats("backpressure_beats", b, 4);
  endtask

  task automatic test_midrun_reset();
    int b;
    t_cmd_dat = pack_cmd(0, 0, 0, 1, 4);
    t_cmd_valid = 1'b1;
    @(negedge clk);
    t_cmd_valid = 1'b0;
    i_kp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (i_kp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset_valid: got %b want 0", i_kp_valid);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (i_kp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_no_resume: valid %b want 0", i_kp_valid);
      end
    end
    run_cmd(1, 1, 2, 0, 0, 0, 1'b0, '0, b);
    expect_beats("post_reset_beats", b, 1);
  endtask

  task automatic test_back_to_back();
    int b;
    run_cmd(1, 0, 6, 3, 2, 1, 1'b1, pack_cmd(2, 1, 4, 2, 1), b);
    expect_beats("held_first_beats", b, 3);
    run_cmd(2, 1, 4, 2, 1, 1, 1'b0, '0, b);
    expect_beats("held_second_beats", b, 2);
  endtask

  task automatic test_random();
    int b, len;
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(0, 5);
      run_cmd($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, SLICES - 1),
              $urandom_range(0, 3), len, 1, 1'b0, '0, b);
      expect_beats("random_beats", b, len + 1);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate_step();
    test_wrap();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
